// File: rtl/usb_pkg.sv
// Shared types for the USB full-speed receive controller: decoded PID codes,
// raw on-wire PID nibbles and the receive FSM state encoding.
package usb_pkg;

  typedef enum logic [2:0] {
    PID_NONE  = 3'd0,
    PID_OUT   = 3'd1,
    PID_IN    = 3'd2,
    PID_DATA0 = 3'd3,
    PID_DATA1 = 3'd4,
    PID_ACK   = 3'd5,
    PID_NAK   = 3'd6,
    PID_STALL = 3'd7
  } rx_pid_t;

  localparam logic [3:0] RAW_OUT   = 4'b0001;
  localparam logic [3:0] RAW_IN    = 4'b1001;
  localparam logic [3:0] RAW_DATA0 = 4'b0011;
  localparam logic [3:0] RAW_DATA1 = 4'b1011;
  localparam logic [3:0] RAW_ACK   = 4'b0010;
  localparam logic [3:0] RAW_NAK   = 4'b1010;
  localparam logic [3:0] RAW_STALL = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_EOP_WAIT,
    ST_DONE,
    ST_ERR
  } rx_ctrl_state_t;

endpackage

// File: rtl/usb_pid_decode.sv
// Combinational PID check: upper nibble must be the complement of the lower
// nibble, and the lower nibble must be one of the supported PIDs.
module usb_pid_decode
  import usb_pkg::*;
(
  input  logic [7:0] i_rcv_data,
  output logic       o_valid,
  output rx_pid_t    o_pid
);

  always_comb begin
    o_valid = 1'b0;
    o_pid   = PID_NONE;
    if (i_rcv_data[7:4] == ~i_rcv_data[3:0]) begin
      o_valid = 1'b1;
      unique case (i_rcv_data[3:0])
        RAW_OUT:   o_pid = PID_OUT;
        RAW_IN:    o_pid = PID_IN;
        RAW_DATA0: o_pid = PID_DATA0;
        RAW_DATA1: o_pid = PID_DATA1;
        RAW_ACK:   o_pid = PID_ACK;
        RAW_NAK:   o_pid = PID_NAK;
        RAW_STALL: o_pid = PID_STALL;
        default:   o_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive control FSM: validates SYNC/PID, gates payload bytes
// into the RX FIFO and checks EOP alignment and packet length.
module usb_rx_ctrl
  import usb_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = 8'h80,
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_enable,
  input  logic             byte_received,
  input  logic [7:0]       rcv_data,
  output logic             rcving,
  output logic             w_enable,
  output logic [2:0]       rx_packet,
  output logic             store_rx_packet,
  output logic             packet_done,
  output logic             r_error,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DATA_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(2);

  rx_ctrl_state_t   r_state, w_state_nxt;
  logic [2:0]       r_bits, w_bits_nxt, w_bits_eff;
  logic [1:0]       r_tok_cnt, w_tok_nxt;
  logic             r_eop_seen, w_eop_seen_nxt;
  logic             r_rst_hold;
  logic             w_rcving_nxt, w_wen_nxt, w_store_nxt, w_done_nxt, w_err_nxt;
  logic [2:0]       w_pkt_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pid_valid;
  rx_pid_t          w_pid;

  usb_pid_decode u_pid_decode (
    .i_rcv_data (rcv_data),
    .o_valid    (w_pid_valid),
    .o_pid      (w_pid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_bits          <= 3'd0;
      r_tok_cnt       <= 2'd0;
      r_eop_seen      <= 1'b0;
      r_rst_hold      <= 1'b1;
      rcving          <= 1'b0;
      w_enable        <= 1'b0;
      rx_packet       <= 3'd0;
      store_rx_packet <= 1'b0;
      packet_done     <= 1'b0;
      r_error         <= 1'b0;
      byte_count      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_bits          <= w_bits_nxt;
      r_tok_cnt       <= w_tok_nxt;
      r_eop_seen      <= w_eop_seen_nxt;
      r_rst_hold      <= 1'b0;
      rcving          <= w_rcving_nxt;
      w_enable        <= w_wen_nxt;
      rx_packet       <= w_pkt_nxt;
      store_rx_packet <= w_store_nxt;
      packet_done     <= w_done_nxt;
      r_error         <= w_err_nxt;
      byte_count      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tok_nxt      = r_tok_cnt;
    w_eop_seen_nxt = r_eop_seen;
    w_rcving_nxt   = rcving;
    w_wen_nxt      = 1'b0;
    w_pkt_nxt      = rx_packet;
    w_store_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_error;
    w_cnt_nxt      = byte_count;
    // A byte completing in the same cycle as eop counts as aligned
    w_bits_eff     = byte_received ? 3'd0 : r_bits;
    w_bits_nxt     = byte_received ? 3'd0 : (shift_enable ? r_bits + 3'd1 : r_bits);

    unique case (r_state)
      ST_IDLE: begin
        if (d_edge && !r_rst_hold) begin
          w_state_nxt    = ST_SYNC;
          w_rcving_nxt   = 1'b1;
          w_err_nxt      = 1'b0;
          w_cnt_nxt      = '0;
          w_bits_nxt     = 3'd0;
          w_tok_nxt      = 2'd0;
          w_eop_seen_nxt = 1'b0;
        end
      end
      ST_SYNC: begin
        if (eop) w_state_nxt = ST_ERR;
        else if (byte_received) w_state_nxt = (rcv_data == SYNC_BYTE) ? ST_PID : ST_ERR;
      end
      ST_PID: begin
        if (byte_received) begin
          if (!w_pid_valid) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_pkt_nxt   = w_pid;
            w_store_nxt = 1'b1;
            if (w_pid == PID_DATA0 || w_pid == PID_DATA1) begin
              w_state_nxt = eop ? ST_ERR : ST_DATA;
            end else if (w_pid == PID_OUT || w_pid == PID_IN) begin
              w_state_nxt = eop ? ST_ERR : ST_TOKEN;
            end else begin
              w_state_nxt    = ST_EOP_WAIT;
              w_eop_seen_nxt = eop;
            end
          end
        end else if (eop) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_TOKEN: begin
        if (byte_received) begin
          if (r_tok_cnt == 2'd2) w_state_nxt = ST_ERR;
          else w_tok_nxt = r_tok_cnt + 2'd1;
        end
        if (eop && w_state_nxt == ST_TOKEN) begin
          if (w_bits_eff != 3'd0 || w_tok_nxt != 2'd2) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt    = ST_EOP_WAIT;
            w_eop_seen_nxt = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // Payload plus CRC16 may not exceed MAX_DATA_BYTES+2 bytes
        if (byte_received) begin
          if (byte_count == CNT_LIMIT) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_wen_nxt = 1'b1;
            w_cnt_nxt = (byte_count == CNT_SAT) ? byte_count : byte_count + CNT_W'(1);
          end
        end
        if (eop && w_state_nxt == ST_DATA) begin
          if (w_bits_eff != 3'd0 || w_cnt_nxt < CNT_MIN) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt    = ST_EOP_WAIT;
            w_eop_seen_nxt = 1'b1;
          end
        end
      end
      ST_EOP_WAIT: begin
        if (r_eop_seen) begin
          if (!eop && d_edge) begin
            w_state_nxt  = ST_DONE;
            w_done_nxt   = 1'b1;
            w_rcving_nxt = 1'b0;
          end
        end else if (byte_received) begin
          w_state_nxt = ST_ERR;
        end else if (eop) begin
          if (r_bits != 3'd0) w_state_nxt = ST_ERR;
          else w_eop_seen_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        if (eop) begin
          w_eop_seen_nxt = 1'b1;
        end else if (r_eop_seen && d_edge) begin
          w_state_nxt  = ST_IDLE;
          w_rcving_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_rcving_nxt = 1'b0;
      end
    endcase

    // Entering ERR: raise the sticky flag and remember whether eop is already on the bus
    if (w_state_nxt == ST_ERR && r_state != ST_ERR) begin
      w_err_nxt      = 1'b1;
      w_eop_seen_nxt = eop;
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: a byte-level packet model predicts every
// output each cycle; literal checks pin the model at the end of each packet.
module tb_usb_rx_ctrl;

  logic       clk, rst, d_edge, eop, shift_enable, byte_received;
  logic [7:0] rcv_data;
  logic       rcving, w_enable, store_rx_packet, packet_done, r_error;
  logic [2:0] rx_packet;
  logic [6:0] byte_count;

  int n_checks, n_errors;
  int n_wen, n_store, n_done;

  // Expected outputs
  int m_rcving, m_wen, m_pkt, m_store, m_done, m_err, m_cnt;
  // Packet-level model state
  int a_on, a_nb, a_bits, a_kind, a_failed, a_eop, a_cooldown, a_hold;

  usb_rx_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .d_edge          (d_edge),
    .eop             (eop),
    .shift_enable    (shift_enable),
    .byte_received   (byte_received),
    .rcv_data        (rcv_data),
    .rcving          (rcving),
    .w_enable        (w_enable),
    .rx_packet       (rx_packet),
    .store_rx_packet (store_rx_packet),
    .packet_done     (packet_done),
    .r_error         (r_error),
    .byte_count      (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Byte value -> decoded PID code, 0 when not a legal PID byte
  function automatic int pid_code(input logic [7:0] b);
    case (b)
      8'hE1:   return 1;
      8'h69:   return 2;
      8'hC3:   return 3;
      8'h4B:   return 4;
      8'hD2:   return 5;
      8'h5A:   return 6;
      8'h1E:   return 7;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_rcving = 0; m_wen = 0; m_pkt = 0; m_store = 0; m_done = 0; m_err = 0; m_cnt = 0;
    a_on = 0; a_nb = 0; a_bits = 0; a_kind = 0; a_failed = 0; a_eop = 0;
    a_cooldown = 0; a_hold = 1;
  endtask

  // One clock edge of the packet model; a_kind: 1 token, 2 data, 3 handshake
  task automatic model_step(input logic de, input logic ev, input logic se,
                            input logic br, input logic [7:0] data);
    int hold, bad, code;
    m_wen = 0; m_store = 0; m_done = 0;
    hold = a_hold; a_hold = 0;
    if (a_cooldown != 0) begin
      a_cooldown = 0;
    end else if (a_on == 0) begin
      if (de && hold == 0) begin
        a_on = 1; a_nb = 0; a_bits = 0; a_kind = 0; a_failed = 0; a_eop = 0;
        m_rcving = 1; m_err = 0; m_cnt = 0;
      end
    end else if (a_failed != 0) begin
      if (ev) a_eop = 1;
      else if (a_eop != 0 && de) begin a_on = 0; m_rcving = 0; end
    end else if (a_eop != 0) begin
      if (!ev && de) begin a_on = 0; m_rcving = 0; m_done = 1; a_cooldown = 1; end
    end else begin
      bad = 0;
      if (br) begin
        a_nb++;
        a_bits = 0;
        if (a_nb == 1) begin
          bad = (data != 8'h80) ? 1 : 0;
        end else if (a_nb == 2) begin
          code = pid_code(data);
          if (code == 0) bad = 1;
          else begin
            m_pkt = code; m_store = 1;
            a_kind = (code <= 2) ? 1 : ((code <= 4) ? 2 : 3);
          end
        end else if (a_kind == 1) begin
          bad = (a_nb > 4) ? 1 : 0;
        end else if (a_kind == 2) begin
          if (a_nb - 2 > 66) bad = 1;
          else begin m_wen = 1; m_cnt++; end
        end else begin
          bad = 1;
        end
      end else if (se) begin
        a_bits = (a_bits + 1) % 8;
      end
      if (bad == 0 && ev) begin
        if (a_bits != 0 || a_nb < 2) bad = 1;
        else if (a_kind == 2 && m_cnt < 2) bad = 1;
        else if (a_kind == 1 && a_nb != 4) bad = 1;
        else a_eop = 1;
      end
      if (bad != 0) begin a_failed = 1; m_err = 1; a_eop = ev ? 1 : 0; end
    end
  endtask

  task automatic compare_outputs();
    check("rcving",          int'(rcving),          m_rcving);
    check("w_enable",        int'(w_enable),        m_wen);
    check("rx_packet",       int'(rx_packet),       m_pkt);
    check("store_rx_packet", int'(store_rx_packet), m_store);
    check("packet_done",     int'(packet_done),     m_done);
    check("r_error",         int'(r_error),         m_err);
    check("byte_count",      int'(byte_count),      m_cnt);
    n_wen   += int'(w_enable);
    n_store += int'(store_rx_packet);
    n_done  += int'(packet_done);
  endtask

  // Drive at the falling edge, model at the rising edge, compare at the next falling edge
  task automatic cyc(input logic de, input logic ev, input logic se,
                     input logic br, input logic [7:0] data);
    d_edge = de; eop = ev; shift_enable = se; byte_received = br; rcv_data = data;
    @(posedge clk);
    model_step(de, ev, se, br, data);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(7);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, b);
  endtask

  task automatic start_pkt();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic eop_end();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
  endtask

  task automatic do_reset();
    rst = 1'b1; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    compare_outputs();
    rst = 1'b0;
  endtask

  task automatic clr_counts();
    n_wen = 0; n_store = 0; n_done = 0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    clr_counts();
    rst = 1'b1; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;
    @(negedge clk);
    do_reset();
    check("reset_rcving", int'(rcving), 0);
    check("reset_rx_packet", int'(rx_packet), 0);
    // Edge in the first cycle out of reset must be ignored
    start_pkt();
    check("edge_at_reset_release", int'(rcving), 0);
    idle(2);

    // ACK handshake
    clr_counts();
    start_pkt(); send_byte(8'h80); send_byte(8'hD2); eop_end();
    check("ack_rx_packet", int'(rx_packet), 5);
    check("ack_store_pulses", n_store, 1);
    check("ack_done_pulses", n_done, 1);
    check("ack_wen_pulses", n_wen, 0);
    check("ack_r_error", int'(r_error), 0);

    // DATA0 with two payload bytes and CRC16
    clr_counts();
    start_pkt(); send_byte(8'h80); send_byte(8'hC3);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h12); send_byte(8'h34);
    eop_end();
    check("data0_wen_pulses", n_wen, 4);
    check("data0_byte_count", int'(byte_count), 4);
    check("data0_rx_packet", int'(rx_packet), 3);
    check("data0_done_pulses", n_done, 1);

    // Bad PID complement
    clr_counts();
    start_pkt(); send_byte(8'h80); send_byte(8'hC4);
    check("badpid_r_error", int'(r_error), 1);
    eop_end();
    check("badpid_store_pulses", n_store, 0);
    check("badpid_rx_packet", int'(rx_packet), 3);
    check("badpid_done_pulses", n_done, 0);
    check("badpid_rcving", int'(rcving), 0);

    // DATA1 with EOP three bits into a byte
    clr_counts();
    start_pkt();
    check("start_clears_error", int'(r_error), 0);
    send_byte(8'h80); send_byte(8'h4B); send_byte(8'h11); send_byte(8'h22);
    send_bits(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("misalign_r_error", int'(r_error), 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
    check("misalign_done_pulses", n_done, 0);
    check("misalign_rx_packet", int'(rx_packet), 4);

    // NAK whose last byte coincides with EOP
    clr_counts();
    start_pkt(); send_byte(8'h80); send_bits(7);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
    check("nak_rx_packet", int'(rx_packet), 6);
    check("nak_done_pulses", n_done, 1);
    check("nak_r_error", int'(r_error), 0);

    // Reset in the middle of a DATA0 payload
    clr_counts();
    start_pkt(); send_byte(8'h80); send_byte(8'hC3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check("pre_reset_byte_count", int'(byte_count), 3);
    do_reset();
    check("midrst_rcving", int'(rcving), 0);
    check("midrst_byte_count", int'(byte_count), 0);
    check("midrst_rx_packet", int'(rx_packet), 0);
    idle(2);

    // Clean IN token after the reset
    clr_counts();
    start_pkt(); send_byte(8'h80); send_byte(8'h69); send_byte(8'h15); send_byte(8'hA8);
    eop_end();
    check("in_rx_packet", int'(rx_packet), 2);
    check("in_done_pulses", n_done, 1);
    check("in_wen_pulses", n_wen, 0);

    // Oversized DATA0: 64 payload + 2 CRC + 1 extra
    clr_counts();
    start_pkt(); send_byte(8'h80); send_byte(8'hC3);
    for (int i = 0; i < 67; i++) send_byte(8'(i));
    check("long_wen_pulses", n_wen, 66);
    check("long_r_error", int'(r_error), 1);
    check("long_byte_count", int'(byte_count), 66);
    eop_end();
    check("long_done_pulses", n_done, 0);
    check("long_rcving", int'(rcving), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
Control FSM that sequences the USB full-speed receive datapath (edge detector, NRZI decoder, bit timer, 8-bit shift register, RX FIFO). It validates SYNC and PID, gates data bytes into the RX FIFO, and checks EOP alignment and packet length. It reports the packet type, completion and error status to the protocol layer.

Parameters:
SYNC_BYTE, 8'h80, value on rcv_data when the SYNC field (KJKJKJKK) has been shifted in
MAX_DATA_BYTES, 64, maximum data-phase payload bytes, excluding PID and CRC16
CNT_W, 7, width of byte_count; must satisfy 2**CNT_W > MAX_DATA_BYTES+2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
d_edge  in  1  one-cycle pulse on a D+ transition, from the edge detector
eop  in  1  level, high while D+ and D- are both 0 (sampled)
shift_enable  in  1  one-cycle pulse per sampled bit, from the bit timer
byte_received  in  1  one-cycle pulse, rcv_data holds a complete byte this cycle
rcv_data  in  8  shift-register contents
rcving  out  1  bit timer enable; high from the start edge to the end of the packet
w_enable  out  1  one-cycle RX FIFO write strobe for a payload byte
rx_packet  out  3  decoded PID code (usb_pkg::rx_pid_t), held until the next PID is decoded
store_rx_packet  out  1  one-cycle pulse when rx_packet updates
packet_done  out  1  one-cycle pulse on a clean end of packet
r_error  out  1  sticky error flag, cleared at the next start edge
byte_count  out  CNT_W  payload bytes written for the current packet

Behaviour:
- Reset (asynchronous, any state): state=IDLE. rcving=0, w_enable=0, rx_packet=PID_NONE(0), store_rx_packet=0, packet_done=0, r_error=0, byte_count=0. All outputs are registered.
- IDLE: on d_edge go to SYNC, set rcving=1, clear r_error, clear byte_count, clear the bit counter.
- bits counter (3 bits): increments on shift_enable and clears on byte_received.
- SYNC: on byte_received, go to PID if rcv_data==SYNC_BYTE, otherwise go to ERR. eop in SYNC goes to ERR.
- PID: on byte_received, check that rcv_data[7:4]==~rcv_data[3:0] and that the nibble is a known PID: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
  - Valid PID: rx_packet<=code. store_rx_packet pulses in the next cycle. Go to DATA for DATA0/DATA1, to TOKEN for OUT/IN, to EOP_WAIT for handshakes.
  - Invalid PID: go to ERR. rx_packet is unchanged and no store pulse is generated.
- TOKEN: expects exactly 2 further bytes (address/endp/CRC5), which are not written to the FIFO. A third byte goes to ERR. eop after 2 bytes goes to EOP_WAIT.
- DATA: each byte_received gives a w_enable pulse in the next cycle and byte_count+1.
  - Writing byte MAX_DATA_BYTES+3 (payload plus CRC16 exceeded) goes to ERR, with no w_enable for that byte.
- Any state after PID:
  - eop with bits!=0 (misaligned) goes to ERR.
  - eop with bits==0 goes to EOP_WAIT.
  - eop in DATA with byte_count<2 goes to ERR.
- EOP_WAIT: wait for eop=0 and d_edge (return to J), then go to DONE.
- DONE: packet_done=1 for one cycle, rcving=0, go to IDLE.
- ERR: r_error<=1 and stays high. Wait for eop then its release (d_edge), then go to IDLE with rcving=0 and no packet_done.
- Simultaneous eop and byte_received: the byte is processed first, then the EOP check uses bits==0.
- A d_edge in IDLE during the same cycle that rst deasserts is ignored. Reset mid-packet drops the packet; FIFO flushing is owned by the FIFO.
- byte_count saturates at 2**CNT_W-1.

Decomposition:
- usb_pkg: typedef enum logic[2:0] rx_pid_t {PID_NONE=0, PID_OUT=1, PID_IN=2, PID_DATA0=3, PID_DATA1=4, PID_ACK=5, PID_NAK=6, PID_STALL=7}.
- usb_pkg: 4-bit raw PID constants and the state enum rx_ctrl_state_t.
- Sub-module usb_pid_decode: combinational rcv_data to {valid, rx_pid_t}. Everything else lives in one FSM module.

Test Plan:
- Reset mid-DATA (rst pulse after 3 payload bytes) -> all outputs 0 and state IDLE immediately; the next clean packet decodes normally.
- SYNC 8'h80, PID 8'hD2 (ACK), aligned EOP -> rx_packet=5, one store_rx_packet pulse, packet_done one cycle, w_enable never asserts, r_error=0.
- SYNC, PID 8'hC3 (DATA0), payload 8'hA5 8'h3C plus 2 CRC bytes, EOP -> 4 w_enable pulses, byte_count=4, rx_packet=3, packet_done=1.
- SYNC, PID 8'hC4 (bad complement) -> r_error=1, no store pulse, rx_packet unchanged; after EOP, returns to IDLE without packet_done.
- DATA1 with EOP after 3 bits of a byte -> r_error=1, no packet_done; r_error clears on the next start edge.
- DATA0 with 67 bytes (MAX 64 + 2 CRC + 1) -> exactly 66 w_enable pulses, r_error=1 on byte 67.
